// File: rtl/display_pkg.sv
// Shared types, glyph codes and segment patterns for the multiplexed
// seven-segment display driver.
package display_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_SIGNED = 2'd1,
        MODE_PC     = 2'd2,
        MODE_PROMPT = 2'd3
    } mode_e;

    // Glyph codes 0..9 are the decimal digits themselves.
    localparam logic [4:0] GLYPH_DASH  = 5'd10;
    localparam logic [4:0] GLYPH_P     = 5'd11;
    localparam logic [4:0] GLYPH_I     = 5'd12;
    localparam logic [4:0] GLYPH_N     = 5'd13;
    localparam logic [4:0] GLYPH_BLANK = 5'd14;

    // Active-low segment patterns, bit 0 = a ... bit 6 = g.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_I     = 7'h4F;
    localparam logic [6:0] SEG_N     = 7'h2B;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Double-dabble: {hundreds, tens, units} in BCD.
    function automatic logic [11:0] bin8_to_bcd(input logic [7:0] bin);
        logic [11:0] bcd;
        bcd = 12'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bcd[3:0] > 4'd4) begin
                bcd[3:0] = bcd[3:0] + 4'd3;
            end
            if (bcd[7:4] > 4'd4) begin
                bcd[7:4] = bcd[7:4] + 4'd3;
            end
            if (bcd[11:8] > 4'd4) begin
                bcd[11:8] = bcd[11:8] + 4'd3;
            end
            bcd = {bcd[10:0], bin[i]};
        end
        return bcd;
    endfunction

endpackage

// File: rtl/display_seg7_decode.sv
// Glyph code to active-low seven-segment pattern; unknown codes render blank.
module seg7_decode
    import display_pkg::*;
(
    input  logic [4:0] i_glyph,
    output logic [6:0] o_seg
);

    // Pure lookup from glyph code to segment pattern.
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_glyph)
            5'd0:        o_seg = SEG_0;
            5'd1:        o_seg = SEG_1;
            5'd2:        o_seg = SEG_2;
            5'd3:        o_seg = SEG_3;
            5'd4:        o_seg = SEG_4;
            5'd5:        o_seg = SEG_5;
            5'd6:        o_seg = SEG_6;
            5'd7:        o_seg = SEG_7;
            5'd8:        o_seg = SEG_8;
            5'd9:        o_seg = SEG_9;
            GLYPH_DASH:  o_seg = SEG_DASH;
            GLYPH_P:     o_seg = SEG_P;
            GLYPH_I:     o_seg = SEG_I;
            GLYPH_N:     o_seg = SEG_N;
            GLYPH_BLANK: o_seg = SEG_BLANK;
            default:     o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display.sv
// Four-digit multiplexed seven-segment driver plus discrete LEDs, showing an
// idle value, a signed result, the program counter or an input prompt.
module display
    import display_pkg::*;
#(
    parameter int SCAN_BITS  = 18,
    parameter int BLINK_BITS = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] inp,
    input  logic       busy,
    input  logic       inp_take,
    input  logic       pc_disp,
    output logic [6:0] led,
    output logic       d1,
    output logic       d2,
    output logic       d3,
    output logic       d4,
    output logic [7:0] s_led
);

    logic [7:0]            r_inp;
    logic                  r_busy;
    logic                  r_take;
    logic                  r_pc;
    logic [SCAN_BITS-1:0]  r_scan;
    logic [BLINK_BITS-1:0] r_blink;
    logic [6:0]            r_led;
    logic [3:0]            r_dn;
    logic [7:0]            r_s_led;

    mode_e      w_mode;
    logic [7:0] w_bin;
    logic [11:0] w_bcd;
    logic [4:0] w_g1;
    logic [4:0] w_g2;
    logic [4:0] w_g3;
    logic [4:0] w_g4;
    logic [1:0] w_dsel;
    logic [4:0] w_glyph;
    logic [6:0] w_seg;
    logic [3:0] w_dn;
    logic [7:0] w_s_led;

    // Input capture from the CPU control FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inp  <= 8'd0;
            r_busy <= 1'b0;
            r_take <= 1'b0;
            r_pc   <= 1'b0;
        end else begin
            r_inp  <= inp;
            r_busy <= busy;
            r_take <= inp_take;
            r_pc   <= pc_disp;
        end
    end

    // Free-running scan and blink counters; mode changes never disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan  <= '0;
            r_blink <= '0;
        end else begin
            r_scan  <= r_scan + 1'b1;
            r_blink <= r_blink + 1'b1;
        end
    end

    // Mode priority: prompt over PC over signed over idle.
    always_comb begin
        w_mode = MODE_IDLE;
        if (r_take) begin
            w_mode = MODE_PROMPT;
        end else if (r_pc) begin
            w_mode = MODE_PC;
        end else if (r_busy) begin
            w_mode = MODE_SIGNED;
        end else begin
            w_mode = MODE_IDLE;
        end
    end

    // Binary operand for conversion: PC field, signed magnitude or raw value.
    always_comb begin
        w_bin = r_inp;
        case (w_mode)
            MODE_PC:     w_bin = {2'b00, r_inp[5:0]};
            MODE_SIGNED: w_bin = r_inp[7] ? (~r_inp + 8'd1) : r_inp;
            MODE_IDLE:   w_bin = r_inp;
            MODE_PROMPT: w_bin = r_inp;
            default:     w_bin = r_inp;
        endcase
        w_bcd = bin8_to_bcd(w_bin);
    end

    // Per-digit glyphs; numeric modes blank leading zeros but keep the units.
    always_comb begin
        w_g1 = GLYPH_BLANK;
        w_g2 = GLYPH_BLANK;
        w_g3 = GLYPH_BLANK;
        w_g4 = GLYPH_BLANK;
        case (w_mode)
            MODE_PROMPT: begin
                w_g1 = GLYPH_I;
                w_g2 = GLYPH_N;
            end
            MODE_PC: begin
                w_g1 = GLYPH_P;
                w_g3 = {1'b0, w_bcd[7:4]};
                w_g4 = {1'b0, w_bcd[3:0]};
            end
            MODE_SIGNED, MODE_IDLE: begin
                w_g1 = (w_mode == MODE_SIGNED && r_inp[7]) ? GLYPH_DASH : GLYPH_BLANK;
                if (w_bcd[11:8] != 4'd0) begin
                    w_g2 = {1'b0, w_bcd[11:8]};
                end else begin
                    w_g2 = GLYPH_BLANK;
                end
                if (w_bcd[11:4] != 8'd0) begin
                    w_g3 = {1'b0, w_bcd[7:4]};
                end else begin
                    w_g3 = GLYPH_BLANK;
                end
                w_g4 = {1'b0, w_bcd[3:0]};
            end
            default: begin
                w_g1 = GLYPH_BLANK;
            end
        endcase
    end

    // Active digit comes from the top two scan bits; d1 is leftmost.
    always_comb begin
        w_dsel  = r_scan[SCAN_BITS-1 -: 2];
        w_glyph = GLYPH_BLANK;
        w_dn    = 4'b1111;
        case (w_dsel)
            2'd0: begin w_glyph = w_g1; w_dn = 4'b0111; end
            2'd1: begin w_glyph = w_g2; w_dn = 4'b1011; end
            2'd2: begin w_glyph = w_g3; w_dn = 4'b1101; end
            2'd3: begin w_glyph = w_g4; w_dn = 4'b1110; end
            default: begin w_glyph = GLYPH_BLANK; w_dn = 4'b1111; end
        endcase
    end

    seg7_decode u_seg7_decode (
        .i_glyph (w_glyph),
        .o_seg   (w_seg)
    );

    // Discrete LEDs mirror the value except while prompting, where they blink.
    always_comb begin
        if (w_mode == MODE_PROMPT) begin
            w_s_led = r_blink[BLINK_BITS-1] ? 8'hFF : 8'h00;
        end else begin
            w_s_led = r_inp;
        end
    end

    // Registered outputs: segments and enable switch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led   <= 7'h7F;
            r_dn    <= 4'b1111;
            r_s_led <= 8'h00;
        end else begin
            r_led   <= w_seg;
            r_dn    <= w_dn;
            r_s_led <= w_s_led;
        end
    end

    assign led   = r_led;
    assign d1    = r_dn[3];
    assign d2    = r_dn[2];
    assign d3    = r_dn[1];
    assign d4    = r_dn[0];
    assign s_led = r_s_led;

endmodule

// File: tb/tb_display.sv
// Randomized self-checking bench for display against a text-level model:
// each mode is rendered as a 4-character string, then mapped to segments.
module tb_display;

    localparam int SB  = 6;
    localparam int BB  = 8;
    localparam int PER = 2 ** SB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] inp = 8'd0;
    logic       busy = 1'b0;
    logic       inp_take = 1'b0;
    logic       pc_disp = 1'b0;
    logic [6:0] led;
    logic       d1, d2, d3, d4;
    logic [7:0] s_led;

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned n_edge   = 0;
    logic [10:0] reg_q    = 11'd0;   // {inp_take, pc_disp, busy, inp} as captured

    always #5 clk = ~clk;

    display #(.SCAN_BITS(SB), .BLINK_BITS(BB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inp      (inp),
        .busy     (busy),
        .inp_take (inp_take),
        .pc_disp  (pc_disp),
        .led      (led),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .d4       (d4),
        .s_led    (s_led)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n_edge);
        end
    endtask

    // Active-low segments from the list of lit segment letters.
    function automatic logic [6:0] seg_of(input byte c);
        string      lit;
        logic [6:0] s;
        case (c)
            "0": lit = "abcdef";
            "1": lit = "bc";
            "2": lit = "abdeg";
            "3": lit = "abcdg";
            "4": lit = "bcfg";
            "5": lit = "acdfg";
            "6": lit = "acdefg";
            "7": lit = "abc";
            "8": lit = "abcdefg";
            "9": lit = "abcdfg";
            "-": lit = "g";
            "P": lit = "abefg";
            "I": lit = "ef";
            "n": lit = "ceg";
            default: lit = "";
        endcase
        s = 7'h7F;
        for (int i = 0; i < lit.len(); i++) begin
            s[int'(lit[i]) - 97] = 1'b0;
        end
        return s;
    endfunction

    function automatic byte dig(input int v);
        return byte'(48 + v);
    endfunction

    // Four characters the display should show, d1 in the top byte.
    function automatic logic [31:0] text_of(input logic [10:0] r);
        int  v;
        int  mag;
        byte c1, c2, c3, c4;
        v = int'(r[7:0]);
        if (r[10]) begin
            c1 = "I"; c2 = "n"; c3 = " "; c4 = " ";
        end else if (r[9]) begin
            mag = v % 64;
            c1 = "P"; c2 = " "; c3 = dig(mag / 10); c4 = dig(mag % 10);
        end else begin
            if (r[8] && v >= 128) begin
                mag = 256 - v;
                c1 = "-";
            end else begin
                mag = v;
                c1 = " ";
            end
            c2 = (mag >= 100) ? dig(mag / 100) : " ";
            c3 = (mag >= 10) ? dig((mag / 10) % 10) : " ";
            c4 = dig(mag % 10);
        end
        return {c1, c2, c3, c4};
    endfunction

    // One clock: model what was captured, then check outputs at the falling edge.
    task automatic tick();
        logic [10:0] src;
        logic [31:0] txt;
        int          dsel;
        int          phase;
        byte         c;
        @(posedge clk);
        n_edge++;
        src   = reg_q;
        reg_q = {inp_take, pc_disp, busy, inp};
        @(negedge clk);
        dsel  = int'(((n_edge - 1) >> (SB - 2)) % 4);
        phase = int'(((n_edge - 1) >> (BB - 1)) % 2);
        txt   = text_of(src);
        c     = byte'(txt >> (24 - 8 * dsel));
        check("led", {25'd0, led}, {25'd0, seg_of(c)});
        check("digit_en", {28'd0, d1, d2, d3, d4}, {28'd0, 4'b1111 & ~(4'b1000 >> dsel)});
        check("s_led", {24'd0, s_led},
              {24'd0, src[10] ? ((phase != 0) ? 8'hFF : 8'h00) : src[7:0]});
    endtask

    task automatic run(input int k);
        repeat (k) tick();
    endtask

    task automatic drive(input logic [7:0] v, input logic b, input logic t, input logic p);
        inp = v; busy = b; inp_take = t; pc_disp = p;
    endtask

    task automatic check_off(input string tag);
        check({tag, "_led"}, {25'd0, led}, 32'h7F);
        check({tag, "_d"}, {28'd0, d1, d2, d3, d4}, 32'hF);
        check({tag, "_s_led"}, {24'd0, s_led}, 32'h0);
    endtask

    initial begin
        int guard;
        drive(8'hFF, 1'b0, 1'b0, 1'b0);
        #12;
        check_off("reset");
        @(negedge clk);
        rst_n = 1'b1;
        n_edge = 0;
        reg_q = 11'd0;
        run(2 ** (SB - 2) + 4);

        drive(8'd203, 1'b0, 1'b0, 1'b0); run(PER + 2);
        drive(8'd7, 1'b0, 1'b0, 1'b0);   run(PER + 2);
        drive(8'hF6, 1'b1, 1'b0, 1'b0);  run(PER + 2);
        drive(8'h80, 1'b1, 1'b0, 1'b0);  run(PER + 2);
        drive(8'h00, 1'b1, 1'b0, 1'b0);  run(PER + 2);
        drive(8'd5, 1'b1, 1'b0, 1'b1);   run(PER + 2);
        drive(8'd5, 1'b1, 1'b1, 1'b1);   run(2 ** BB + 40);
        drive(8'd5, 1'b1, 1'b0, 1'b1);   run(PER + 2);

        for (int i = 0; i < 16; i++) begin
            drive(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0));
            run(PER / 2 + $urandom_range(0, PER));
        end

        // Async reset while d3 is the active digit.
        drive(8'hA5, 1'b0, 1'b0, 1'b0);
        run(4);
        guard = 0;
        do begin
            tick();
            guard++;
        end while ((((n_edge - 1) >> (SB - 2)) % 4) != 2 && guard < 2 * PER);
        check("d3_active_before_reset", {28'd0, d1, d2, d3, d4}, 32'hD);
        #2 rst_n = 1'b0;
        #1 check_off("async_reset");
        @(negedge clk);
        check_off("reset_held");
        rst_n = 1'b1;
        n_edge = 0;
        reg_q = 11'd0;
        run(PER + 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display.md
Name: display

Overview:
- Drives a 4-digit multiplexed seven-segment display and 8 discrete LEDs from an 8-bit value and three mode flags supplied by the CPU control FSM.
- Shows an idle value, a signed CPU result, the program counter, or an input prompt.
- Sits beside the CPU core, which sets the value and flags and never reads anything back.

Parameters:
- SCAN_BITS, 18: width of the free-running scan counter. Its top 2 bits select the active digit.
- BLINK_BITS, 24: width of the blink counter. Its MSB is the blink phase.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- inp  in  8  value to display.
- busy  in  1  CPU executing; show inp as a signed value.
- inp_take  in  1  CPU waiting for switch input; show the prompt.
- pc_disp  in  1  show inp as the program counter.
- led  out  7  segments, active-low; led[0]=a … led[6]=g.
- d1, d2, d3, d4  out  1 each  digit enables, active-low; d1 is leftmost.
- s_led  out  8  discrete LEDs, active-high.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low (rst_n). Every flop clears immediately on rst_n=0.
- Reset values:
  - led=7'h7F (all segments off).
  - d1..d4=1 (all digits off).
  - s_led=0.
  - Scan counter, blink counter and input registers are 0.
- Input capture: inp, busy, inp_take and pc_disp are registered every clk.
- Outputs: led, d1..d4 and s_led are registered.
- Latency: a change on the inputs appears on the currently enabled digit within 2 clk edges.
- Scan:
  - The scan counter increments every clk and wraps at 2^SCAN_BITS.
  - Digit select is the counter's top 2 bits: 0→d1, 1→d2, 2→d3, 3→d4.
  - Exactly one d is low at any time after the first post-reset edge.
  - Segments and the digit enable change on the same edge.
- Mode priority: inp_take > pc_disp > busy > idle.
  - Prompt (inp_take=1): digits show "I","n",blank,blank.
  - PC (pc_disp=1): d1="P", d2=blank, d3/d4 = tens/units of inp[5:0] in decimal (0–63). The tens digit is always shown, e.g. 5 shows "P 05".
  - Signed (busy=1): inp is two's complement. d1 shows "-" if inp[7]=1, else blank. d2..d4 show the magnitude (0–128) with leading zeros blanked; a units digit of 0 is always shown. inp=8'h80 shows "-128".
  - Idle: inp as unsigned 0–255 in d2..d4 with leading-zero blanking; d1 is blank.
- Segment sets (listed segments lit, i.e. driven 0):
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg.
  - "-"=g, P=abefg, I=ef, n=ceg, blank=none.
- s_led:
  - Equals inp in every mode except prompt.
  - In prompt mode, s_led = 8'hFF while the blink phase is 1 and 8'h00 while it is 0.
  - The blink counter runs continuously and wraps.
- Mode changes mid-scan take effect on the next registered output. The scan and blink counters are not reset by mode changes.
- Binary-to-decimal conversion is combinational from the registered inp: double-dabble or a divide-by-constant.

Decomposition:
- Package display_pkg holds:
  - Localparams for the segment patterns above.
  - The mode enum: MODE_IDLE, MODE_SIGNED, MODE_PC, MODE_PROMPT.
  - A function bin8_to_bcd returning 3 BCD digits.
- One sub-module, seg7_decode: combinational, 5-bit glyph code in, 7-bit active-low segments out. Glyph codes are 0–9, DASH, P, I, N and BLANK.

Test Plan:
- Reset: hold rst_n=0 with inp=8'hFF → led=7'h7F, all d=1, s_led=0. Release → after 1 clk exactly one d is low (d1), and the enable advances to d2 after 2^(SCAN_BITS-2) clocks.
- Idle: inp=8'd203, flags 0 → over one scan period d1 blank, d2="2", d3="0", d4="3"; s_led=8'hCB. Then inp=8'd7 → d2 and d3 blank, d4="7".
- Signed: busy=1, inp=8'hF6 → "-", blank, "1", "0". Then inp=8'h80 → "-128". Then inp=8'h00 → d4="0", others blank.
- PC: pc_disp=1, busy=1, inp=8'd5 → "P", blank, "0", "5" (pc_disp overrides busy).
- Prompt: inp_take=1, pc_disp=1 → "I","n",blank,blank, and s_led toggles between 8'hFF and 8'h00 each 2^(BLINK_BITS-1) clocks. Drop inp_take → the PC display returns within 2 clk.
- Async reset mid-scan: assert rst_n=0 between clock edges while d3 is active → led and d go to the off state immediately, without waiting for a clk edge.
